// File: rtl/jk_excitation_driver.sv
// JK excitation driver: turns a target state into one-cycle J/K drive for a JK bank, then settles.
// Build option JK_CHECK_EN adds a feedback check state with err pulse and saturating err_cnt.
module jk_excitation_driver #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned DC_POLICY  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             jk_valid,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1) + 1;
  localparam logic [WIDTH-1:0] DcVec = (DC_POLICY != 0) ? '1 : '0;

  typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_cur, w_cur_d;
  logic [WIDTH-1:0] r_tgt, w_tgt_d;
  logic [WIDTH-1:0] r_j, w_j_d;
  logic [WIDTH-1:0] r_k, w_k_d;
  logic             r_jk_valid, w_jk_valid_d;
  logic             r_done, w_done_d;
  logic             r_err, w_err_d;
  logic [7:0]       r_err_cnt, w_err_cnt_d;
  logic             r_tgt_ready, w_tgt_ready_d;
  logic [WIDTH-1:0] w_exc_j, w_exc_k;

  // Inverse JK table: a bit that is 0 only needs J, a bit that is 1 only needs K.
  assign w_exc_j = (~r_cur & r_tgt) | (r_cur & DcVec);
  assign w_exc_k = (r_cur & ~r_tgt) | (~r_cur & DcVec);

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_cur_d      = r_cur;
    w_tgt_d      = r_tgt;
    w_j_d        = '0;
    w_k_d        = '0;
    w_jk_valid_d = 1'b0;
    w_done_d     = 1'b0;
    w_err_d      = 1'b0;
    w_err_cnt_d  = r_err_cnt;
    unique case (r_state)
      StIdle: begin
        if (tgt_valid && r_tgt_ready) begin
          w_tgt_d   = tgt;
          w_cur_d   = q_fb;
          w_state_d = StDrive;
        end
      end
      StDrive: begin
        w_j_d        = w_exc_j;
        w_k_d        = w_exc_k;
        w_jk_valid_d = 1'b1;
        w_cnt_d      = '0;
        w_state_d    = StSettle;
      end
      StSettle: begin
        // Spans the strobe cycle plus SETTLE_CYC cycles after the bank clocks.
        if (r_cnt == CntW'(SETTLE_CYC)) begin
`ifdef JK_CHECK_EN
          w_state_d = StCheck;
`else
          w_state_d = StIdle;
          w_done_d  = 1'b1;
`endif
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
`ifdef JK_CHECK_EN
      StCheck: begin
        w_done_d  = 1'b1;
        w_state_d = StIdle;
        if (q_fb != r_tgt) begin
          w_err_d = 1'b1;
          if (r_err_cnt != 8'hFF) begin
            w_err_cnt_d = r_err_cnt + 8'd1;
          end
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
    // Drops on the accept edge, returns one cycle after re-entering idle.
    w_tgt_ready_d = (r_state == StIdle) && (w_state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_tgt       <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_jk_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= 8'h00;
      r_tgt_ready <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_cur       <= w_cur_d;
      r_tgt       <= w_tgt_d;
      r_j         <= w_j_d;
      r_k         <= w_k_d;
      r_jk_valid  <= w_jk_valid_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
      r_err_cnt   <= w_err_cnt_d;
      r_tgt_ready <= w_tgt_ready_d;
    end
  end

  assign tgt_ready = r_tgt_ready;
  assign j         = r_j;
  assign k         = r_k;
  assign jk_valid  = r_jk_valid;
  assign done      = r_done;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (DC_POLICY 0 and 1), each feeding a behavioural 4-bit JK bank.
// Expectations adapt to whether JK_CHECK_EN is defined for the build.
module tb_jk_excitation_driver;

`ifdef JK_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif
  localparam int SettleCyc = 2;
  localparam int DoneLat   = ChkEn ? 3 + SettleCyc : 2 + SettleCyc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] tgt = 4'h0;
  logic       tgt_valid = 1'b0;
  logic       sel = 1'b0;
  logic       stuck = 1'b0;
  logic [3:0] bank0 = 4'h0;
  logic [3:0] bank1 = 4'h0;

  int n_checks = 0;
  int n_errors = 0;

  logic       valid0, valid1, ready0, ready1, jkv0, jkv1, done0, done1, err0, err1;
  logic [3:0] q_fb0, q_fb1, j0, j1, k0, k1;
  logic [7:0] cnt0, cnt1;

  logic       w_ready, w_jkv, w_done, w_err;
  logic [3:0] w_j, w_k, w_qfb;
  logic [7:0] w_cnt;

  always #5 clk = ~clk;

  assign valid0 = tgt_valid & ~sel;
  assign valid1 = tgt_valid & sel;
  assign q_fb0  = stuck ? 4'b0000 : bank0;
  assign q_fb1  = bank1;

  assign w_ready = sel ? ready1 : ready0;
  assign w_jkv   = sel ? jkv1 : jkv0;
  assign w_done  = sel ? done1 : done0;
  assign w_err   = sel ? err1 : err0;
  assign w_j     = sel ? j1 : j0;
  assign w_k     = sel ? k1 : k0;
  assign w_qfb   = sel ? q_fb1 : q_fb0;
  assign w_cnt   = sel ? cnt1 : cnt0;

  // Behavioural JK banks: Q+ = J&~Q | ~K&Q, clocked only on the strobe.
  always @(posedge clk) begin
    if (jkv0 === 1'b1) bank0 <= (j0 & ~bank0) | (~k0 & bank0);
    if (jkv1 === 1'b1) bank1 <= (j1 & ~bank1) | (~k1 & bank1);
  end

  jk_excitation_driver #(.WIDTH(4), .SETTLE_CYC(SettleCyc), .DC_POLICY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tgt(tgt), .tgt_valid(valid0), .tgt_ready(ready0),
    .q_fb(q_fb0), .j(j0), .k(k0), .jk_valid(jkv0), .done(done0), .err(err0), .err_cnt(cnt0)
  );

  jk_excitation_driver #(.WIDTH(4), .SETTLE_CYC(SettleCyc), .DC_POLICY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tgt(tgt), .tgt_valid(valid1), .tgt_ready(ready1),
    .q_fb(q_fb1), .j(j1), .k(k1), .jk_valid(jkv1), .done(done1), .err(err1), .err_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a target and return at the negedge before the accepting posedge.
  task automatic start_txn(input string tag, input logic [3:0] t);
    int n = 0;
    @(negedge clk);
    tgt       = t;
    tgt_valid = 1'b1;
    while (w_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".ready"}, w_ready, 1);
  endtask

  task automatic finish_txn(input string tag, input bit inject, input logic [3:0] next_t,
                            input logic [3:0] ej, input logic [3:0] ek, input logic [3:0] efin,
                            input logic eerr, input logic [7:0] ecnt);
    int n;
    bit saw_ready = 1'b0;
    @(negedge clk);
    tgt_valid = 1'b0;
    check({tag, ".ready_drop"}, w_ready, 0);
    @(negedge clk);
    check({tag, ".jk_valid"}, w_jkv, 1);
    check({tag, ".j"}, w_j, ej);
    check({tag, ".k"}, w_k, ek);
    @(negedge clk);
    check({tag, ".jk_valid_off"}, w_jkv, 0);
    check({tag, ".q_fb"}, w_qfb, efin);
    if (inject) begin
      tgt       = next_t;
      tgt_valid = 1'b1;
    end
    n = 2;
    while (w_done !== 1'b1 && n < 16) begin
      if (w_ready === 1'b1) saw_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, ".done_lat"}, n, DoneLat);
    check({tag, ".err"}, w_err, eerr);
    check({tag, ".err_cnt"}, w_cnt, ecnt);
    if (inject) begin
      check({tag, ".ready_held_low"}, saw_ready, 0);
      check({tag, ".ready_at_done"}, w_ready, 0);
      @(negedge clk);
      check({tag, ".ready_after_done"}, w_ready, 1);
    end
  endtask

  task automatic run_txn(input string tag, input logic [3:0] t, input logic [3:0] ej,
                         input logic [3:0] ek, input logic [3:0] efin, input logic eerr,
                         input logic [7:0] ecnt);
    start_txn(tag, t);
    finish_txn(tag, 1'b0, 4'h0, ej, ek, efin, eerr, ecnt);
  endtask

  task automatic quiet_txn(input logic [3:0] t);
    int n = 0;
    start_txn("quiet", t);
    @(negedge clk);
    tgt_valid = 1'b0;
    while (w_done !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("quiet.timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_done;

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst.j", j0, 0);
    check("rst.k", k0, 0);
    check("rst.jk_valid", jkv0, 0);
    check("rst.done", done0, 0);
    check("rst.err", err0, 0);
    check("rst.err_cnt", cnt0, 0);
    check("rst.ready0", ready0, 1);
    check("rst.ready1", ready1, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sel = 1'b0;
    run_txn("dc0", 4'b1010, 4'b1010, 4'b0000, 4'b1010, 1'b0, 8'd0);

    sel = 1'b1;
    run_txn("dc1_pre", 4'b1100, 4'b1100, 4'b1111, 4'b1100, 1'b0, 8'd0);
    run_txn("dc1", 4'b0110, 4'b1110, 4'b1011, 4'b0110, 1'b0, 8'd0);

    // Target equals present state: still strobes, with all-hold drive.
    sel = 1'b0;
    run_txn("hold", 4'b1010, 4'b0000, 4'b0000, 4'b1010, 1'b0, 8'd0);

    // New target offered during settle must wait for the idle cycle after done.
    start_txn("hs1", 4'b0101);
    finish_txn("hs1", 1'b1, 4'b0011, 4'b0101, 4'b1010, 4'b0101, 1'b0, 8'd0);
    finish_txn("hs2", 1'b0, 4'h0, 4'b0010, 4'b0100, 4'b0011, 1'b0, 8'd0);

    // Reset in the middle of settle.
    start_txn("mid", 4'b1100);
    @(negedge clk);
    tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid.ready", w_ready, 1);
    check("mid.jk_valid", w_jkv, 0);
    check("mid.done", w_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (w_done === 1'b1) saw_done = 1'b1;
    end
    check("mid.no_done", saw_done, 0);
    check("mid.ready_after", w_ready, 1);
    run_txn("post_rst", 4'b0000, 4'b0000, 4'b1100, 4'b0000, 1'b0, 8'd0);

    // Feedback stuck at zero.
    stuck = 1'b1;
    run_txn("fault", 4'b0001, 4'b0001, 4'b0000, 4'b0000, ChkEn, ChkEn ? 8'd1 : 8'd0);
    for (int i = 0; i < 298; i++) quiet_txn(4'b0001);
    run_txn("fault_sat", 4'b0001, 4'b0001, 4'b0000, 4'b0000, ChkEn, ChkEn ? 8'hFF : 8'h00);
    stuck = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
